window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the image-processing filter stage. It accepts one 24-bit RGB pixel per handshake in raster order and buffers the two previous image rows. It presents a full 3x3 window (colour_o0..colour_o8) plus the centre coordinate, ready to drive the filter's nine colour inputs. Only interior centres are emitted; border pixels are never produced.

---
 rtl/window_3x3_gen.sv | 119 +++++++++++
 tb/tb_window_3x3_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: buffers two image rows and emits the
// full window around every interior pixel in raster order, with its centre coordinate.
module window_3x3_gen #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned XW     = 8,
    parameter int unsigned YW     = 7
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [23:0]   in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   colour_o0,
    output logic [23:0]   colour_o1,
    output logic [23:0]   colour_o2,
    output logic [23:0]   colour_o3,
    output logic [23:0]   colour_o4,
    output logic [23:0]   colour_o5,
    output logic [23:0]   colour_o6,
    output logic [23:0]   colour_o7,
    output logic [23:0]   colour_o8,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_last
);

    localparam int unsigned PW = 24;
    localparam int unsigned NW = 9;

    logic [PW-1:0] lb_a [WIDTH];
    logic [PW-1:0] lb_b [WIDTH];
    logic [PW-1:0] win  [NW];
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept;
    logic          x_end;
    logic          y_end;
    logic          interior;
    logic [PW-1:0] top;
    logic [PW-1:0] mid;

    assign in_ready = !start && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign x_end    = (x == XW'(WIDTH - 1));
    assign y_end    = (y == YW'(HEIGHT - 1));
    assign interior = (x >= XW'(2)) && (y >= YW'(2));
    assign top      = lb_b[x];
    assign mid      = lb_a[x];

    assign colour_o0 = win[0];
    assign colour_o1 = win[1];
    assign colour_o2 = win[2];
    assign colour_o3 = win[3];
    assign colour_o4 = win[4];
    assign colour_o5 = win[5];
    assign colour_o6 = win[6];
    assign colour_o7 = win[7];
    assign colour_o8 = win[8];

    // Row buffers: lb_a ages into lb_b as each column is overwritten
    always_ff @(posedge clock) begin
        if (accept) begin
            lb_b[x] <= lb_a[x];
            lb_a[x] <= in_pixel;
        end
    end

    // Position counters, window shift and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x         <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            for (int i = 0; i < NW; i++) win[i] <= '0;
        end else if (start) begin
            x         <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= top;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= mid;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_pixel;
            // Windows centred on border pixels hold stale/cross-row data
            if (interior) begin
                out_valid <= 1'b1;
                out_x     <= x - XW'(1);
                out_y     <= y - YW'(1);
                out_last  <= x_end && y_end;
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image: plain streaming, stalls,
// back-to-back frames, start restart and asynchronous reset mid-row.
module tb_window_3x3_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned XW = 2;
    localparam int unsigned YW = 2;

    logic          clock = 1'b0;
    logic          resetn;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [23:0]   colour_o0, colour_o1, colour_o2, colour_o3, colour_o4;
    logic [23:0]   colour_o5, colour_o6, colour_o7, colour_o8;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_last;

    logic [23:0] col [9];
    int errors = 0;
    int checks = 0;
    int sx = 0;
    int sy = 0;
    int widx = 0;

    always #5 clock = ~clock;

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .colour_o0(colour_o0), .colour_o1(colour_o1), .colour_o2(colour_o2),
        .colour_o3(colour_o3), .colour_o4(colour_o4), .colour_o5(colour_o5),
        .colour_o6(colour_o6), .colour_o7(colour_o7), .colour_o8(colour_o8),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    assign col[0] = colour_o0;
    assign col[1] = colour_o1;
    assign col[2] = colour_o2;
    assign col[3] = colour_o3;
    assign col[4] = colour_o4;
    assign col[5] = colour_o5;
    assign col[6] = colour_o6;
    assign col[7] = colour_o7;
    assign col[8] = colour_o8;

    function automatic logic [23:0] pix(input int px, input int py);
        logic [3:0] xx;
        logic [3:0] yy;
        xx = 4'(px);
        yy = 4'(py);
        return {yy, xx, yy, xx, yy, xx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected window for the widx-th consumed window of a frame
    task automatic check_window();
        int k;
        int cx;
        int cy;
        k  = widx % int'((W - 2) * (H - 2));
        cx = 1 + k % int'(W - 2);
        cy = 1 + k / int'(W - 2);
        for (int i = 0; i < 9; i++)
            chk($sformatf("win%0d_o%0d", widx, i), 32'(col[i]),
                32'(pix(cx - 1 + i % 3, cy - 1 + i / 3)));
        chk($sformatf("win%0d_x", widx), 32'(out_x), 32'(cx));
        chk($sformatf("win%0d_y", widx), 32'(out_y), 32'(cy));
        chk($sformatf("win%0d_last", widx), 32'(out_last), 32'(k == 3));
    endtask

    // Called at a negedge; streams npix pixels, optionally draining the output
    task automatic run(input int npix, input bit stall, input bit drain);
        int left;
        int cyc;
        logic rdy;
        logic exp_rdy;
        logic ov;
        logic [3:0] pat;
        left = npix;
        cyc  = 0;
        pat  = 4'b1001;
        while ((left > 0 || (drain && out_valid)) && cyc < 300) begin
            ov = out_valid;
            if (ov) check_window();
            rdy       = stall ? pat[cyc % 4] : 1'b1;
            out_ready = rdy;
            in_valid  = (left > 0);
            in_pixel  = pix(sx, sy);
            exp_rdy   = !(ov && !rdy);
            #1;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            @(posedge clock);
            if (ov && rdy) widx++;
            if (in_valid && exp_rdy) begin
                left--;
                if (sx == int'(W - 1)) begin
                    sx = 0;
                    sy = (sy == int'(H - 1)) ? 0 : sy + 1;
                end else begin
                    sx++;
                end
            end
            @(negedge clock);
            in_valid = 1'b0;
            cyc++;
        end
        if (cyc >= 300) chk("run_timeout", 32'(cyc), 32'(0));
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_pixel  = '0;
        repeat (2) @(negedge clock);
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_x", 32'(out_x), 32'(0));
        chk("rst_y", 32'(out_y), 32'(0));
        chk("rst_o4", 32'(colour_o4), 32'(0));
        resetn = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 32'(1));
        @(negedge clock);

        // Continuous stream, out_ready high
        widx = 0;
        run(16, 1'b0, 1'b1);
        chk("plain_count", 32'(widx), 32'(4));

        // out_ready toggling 1,0,0,1
        widx = 0;
        run(16, 1'b1, 1'b1);
        chk("stall_count", 32'(widx), 32'(4));

        // Two frames back to back
        widx = 0;
        run(32, 1'b0, 1'b1);
        chk("b2b_count", 32'(widx), 32'(8));

        // start after 7 pixels; pixel offered during start is dropped
        widx = 0;
        run(7, 1'b0, 1'b1);
        start    = 1'b1;
        in_valid = 1'b1;
        in_pixel = 24'hABCDEF;
        #1;
        chk("start_ready", 32'(in_ready), 32'(0));
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b0;
        sx = 0;
        sy = 0;
        chk("start_valid", 32'(out_valid), 32'(0));
        run(16, 1'b0, 1'b1);
        chk("start_count", 32'(widx), 32'(4));

        // Asynchronous reset while a window is being presented
        widx = 0;
        run(11, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        chk("pre_rst_o4", 32'(colour_o4), 32'(24'h111111));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'(0));
        chk("arst_last", 32'(out_last), 32'(0));
        chk("arst_x", 32'(out_x), 32'(0));
        chk("arst_y", 32'(out_y), 32'(0));
        chk("arst_o4", 32'(colour_o4), 32'(0));
        chk("arst_o8", 32'(colour_o8), 32'(0));
        @(negedge clock);
        resetn = 1'b1;
        sx = 0;
        sy = 0;
        widx = 0;
        @(negedge clock);
        run(16, 1'b0, 1'b1);
        chk("arst_count", 32'(widx), 32'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
